// File: rtl/pipeline_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
// The request fields stay stable while dmem_req is high. dmem_ready completes the access.
interface pipeline_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_wstrb;
    logic              dmem_ready;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/pipeline_lsu.sv
// MEM-stage load/store unit. It accepts one load or store from the pipeline and issues
// one word-aligned request with byte strobes to the data memory. It stalls the pipeline
// until the access finishes and returns extended load data one cycle after completion.
// Rejected accesses and accesses that time out are reported as one-cycle fault pulses.
module pipeline_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd_in,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic [4:0]        rd_out,
    output logic              fault,
    output logic [1:0]        fault_cause,
    pipeline_lsu_if.master    dmem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // The abort fires on the wait cycle that brings the count up to TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [4:0]        r_rd;
    logic              r_load_valid;
    logic [31:0]       r_load_data;
    logic [4:0]        r_rd_out;
    logic              r_fault;
    logic [1:0]        r_cause;

    logic              w_op;
    logic [1:0]        w_cause;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;

    assign w_op = op_valid & (mem_read | mem_write);

    // Classify the presented op: illegal encodings outrank misalignment.
    always_comb begin
        w_cause = CAUSE_NONE;
        if (mem_read & mem_write)
            w_cause = CAUSE_ILLEGAL;
        else if (mem_read & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
            w_cause = CAUSE_ILLEGAL;
        else if (mem_write & (funct3[2] | (funct3[1:0] == 2'b11)))
            w_cause = CAUSE_ILLEGAL;
        else if ((funct3[1:0] == 2'b01) & addr[0])
            w_cause = CAUSE_MISALIGN;
        else if ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00))
            w_cause = CAUSE_MISALIGN;
    end

    // Place store data on every lane and enable only the addressed bytes.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    // Pick the addressed byte or halfword from the returned word and extend it.
    always_comb begin
        w_byte = dmem.dmem_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dmem.dmem_rdata;
        endcase
    end

    // Access FSM with all bus and result outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'd0;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
            r_rd         <= 5'd0;
            r_load_valid <= 1'b0;
            r_load_data  <= 32'd0;
            r_rd_out     <= 5'd0;
            r_fault      <= 1'b0;
            r_cause      <= 2'b00;
        end else begin
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_cause      <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_op) begin
                        if (w_cause != CAUSE_NONE) begin
                            r_fault <= 1'b1;
                            r_cause <= w_cause;
                        end else begin
                            r_req    <= 1'b1;
                            r_we     <= mem_write;
                            r_addr   <= {addr[ADDR_W-1:2], 2'b00};
                            r_wdata  <= w_wdata;
                            r_wstrb  <= w_wstrb;
                            r_funct3 <= funct3;
                            r_off    <= addr[1:0];
                            r_rd     <= rd_in;
                            r_cnt    <= 8'd0;
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem.dmem_ready) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_load_data  <= w_ext;
                            r_rd_out     <= r_rd;
                            r_load_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == CNT_LAST) begin
                            r_req   <= 1'b0;
                            r_fault <= 1'b1;
                            r_cause <= CAUSE_TIMEOUT;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_cnt   <= 8'd0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Hold the pipeline from the cycle a legal op is seen until the access leaves REQ.
    // The reset term forces stall to 0 while reset is asserted.
    assign stall = reset & ((r_state == S_REQ) |
                            ((r_state == S_IDLE) & w_op & (w_cause == CAUSE_NONE)));

    assign load_valid      = r_load_valid;
    assign load_data       = r_load_data;
    assign rd_out          = r_rd_out;
    assign fault           = r_fault;
    assign fault_cause     = r_cause;
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_wstrb = r_wstrb;

endmodule

// File: tb/tb_pipeline_lsu.sv
// Bench for pipeline_lsu. Each operation is expanded into a timeline of expected
// per-cycle outputs that comes from a transaction-level model. One compare process
// checks the DUT against that timeline on every falling edge. A set of literal
// expectations taken from worked examples is checked against the DUT as well.
module tb_pipeline_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        op_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [4:0]  rd_in;
    logic        stall, load_valid, fault;
    logic [31:0] load_data;
    logic [4:0]  rd_out;
    logic [1:0]  fault_cause;

    pipeline_lsu_if #(.ADDR_W(32)) dm ();

    pipeline_lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd_in      (rd_in),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .rd_out     (rd_out),
        .fault      (fault),
        .fault_cause(fault_cause),
        .dmem       (dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        req;
        logic        lv;
        logic        flt;
        logic [1:0]  cause;
        logic [31:0] ld;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  strb;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Observation counters, cleared at the start of each operation.
    int          n_stall, n_req, n_lv, n_flt;
    logic [31:0] last_ld, last_wd, last_a;
    logic [4:0]  last_rd;
    logic [3:0]  last_strb;
    logic [1:0]  last_cause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model for one access, derived from the size, sign and offset rules.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] word,
                                  output logic [1:0] cause, output logic [3:0] strb,
                                  output logic [31:0] wd, output logic [31:0] ld);
        int size;
        int off;
        logic [31:0] sh;
        size = 1 << int'(f3[1:0]);
        off  = int'(a[1:0]);
        cause = 2'd0;
        if (rd && wr)                                  cause = 2'd2;
        else if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) cause = 2'd2;
        else if (wr && !(f3 inside {3'd0, 3'd1, 3'd2}))             cause = 2'd2;
        else if ((off % size) != 0)                    cause = 2'd1;
        strb = 4'((1 << size) - 1) << off;
        wd   = (size == 1) ? {4{sd[7:0]}} : (size == 2) ? {2{sd[15:0]}} : sd;
        sh   = word >> (8 * off);
        if (size == 1)      ld = f3[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        else if (size == 2) ld = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else                ld = word;
    endfunction

    // Compare process: one timeline entry per cycle; an empty timeline means idle.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("dmem_req", 32'(dm.dmem_req), 32'(e.req));
            chk("load_valid", 32'(load_valid), 32'(e.lv));
            chk("fault", 32'(fault), 32'(e.flt));
            if (e.req) begin
                chk("dmem_we", 32'(dm.dmem_we), 32'(e.we));
                chk("dmem_addr", dm.dmem_addr, e.a);
                chk("dmem_wstrb", 32'(dm.dmem_wstrb), 32'(e.strb));
                if (e.we) chk("dmem_wdata", dm.dmem_wdata, e.wd);
            end
            if (e.lv) begin
                chk("load_data", load_data, e.ld);
                chk("rd_out", 32'(rd_out), 32'(e.rd));
            end
            if (e.flt) chk("fault_cause", 32'(fault_cause), 32'(e.cause));
            if (stall)       n_stall++;
            if (dm.dmem_req) begin
                n_req++;
                last_a    = dm.dmem_addr;
                last_wd   = dm.dmem_wdata;
                last_strb = dm.dmem_wstrb;
            end
            if (load_valid) begin
                n_lv++;
                last_ld = load_data;
                last_rd = rd_out;
            end
            if (fault) begin
                n_flt++;
                last_cause = fault_cause;
            end
        end
    end

    // Present one op, play the memory with 'waits' not-ready cycles, and queue the
    // expected output timeline. Called at #1 after a rising edge; returns likewise.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] rdi, input int waits, input logic [31:0] word);
        logic [1:0]  cause;
        logic [3:0]  strb;
        logic [31:0] wd, ld;
        bit          legal, tmo;
        int          n, ncyc;
        exp_t        e;
        model(rd, wr, f3, a, sd, word, cause, strb, wd, ld);
        legal = (cause == 2'd0);
        tmo   = legal && (waits >= TO);
        n     = !legal ? 0 : (waits < TO) ? waits + 1 : TO;
        ncyc  = n + 2;
        n_stall = 0; n_req = 0; n_lv = 0; n_flt = 0;
        last_ld = '0; last_rd = '0; last_cause = '0;
        last_a = '0; last_wd = '0; last_strb = '0;

        e = '0; e.stall = legal;
        exp_q.push_back(e);
        for (int k = 1; k <= n; k++) begin
            e = '0;
            e.stall = 1'b1; e.req = 1'b1; e.we = wr;
            e.a = {a[31:2], 2'b00}; e.wd = wd; e.strb = strb;
            exp_q.push_back(e);
        end
        e = '0;
        if (!legal) begin
            e.flt = 1'b1; e.cause = cause;
        end else if (tmo) begin
            e.flt = 1'b1; e.cause = 2'd3;
        end else if (rd) begin
            e.lv = 1'b1; e.ld = ld; e.rd = rdi;
        end
        exp_q.push_back(e);

        mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = sd; rd_in = rdi;
        for (int k = 0; k < ncyc; k++) begin
            op_valid = (k == 0) || legal;
            if (legal && k >= 1 && k <= n) begin
                dm.dmem_ready = (k - 1 == waits);
                dm.dmem_rdata = (k - 1 == waits) ? word : $urandom;
            end else begin
                dm.dmem_ready = 1'($urandom);
                dm.dmem_rdata = $urandom;
            end
            @(posedge clk); #1;
        end
        op_valid  = 1'b0;
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        dm.dmem_ready = 1'b0;
        $display("op rd=%0d wr=%0d f3=%0d addr=%h waits=%0d cause=%0d ld=%h", rd, wr, f3, a,
                 waits, cause, ld);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_req"}, 32'(dm.dmem_req), 32'd0);
        chk({tag, "_lv"}, 32'(load_valid), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_cause"}, 32'(fault_cause), 32'd0);
        chk({tag, "_ld"}, load_data, 32'd0);
        chk({tag, "_rd"}, 32'(rd_out), 32'd0);
        chk({tag, "_we"}, 32'(dm.dmem_we), 32'd0);
        chk({tag, "_addr"}, dm.dmem_addr, 32'd0);
        chk({tag, "_wdata"}, dm.dmem_wdata, 32'd0);
        chk({tag, "_wstrb"}, 32'(dm.dmem_wstrb), 32'd0);
    endtask

    localparam logic [31:0] MW = 32'h80FF7F01;

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

        reset = 1'b0; op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = '0; store_data = '0; rd_in = '0;
        dm.dmem_ready = 1'b0; dm.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // SW with two wait cycles.
        run_op(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0, 2, 32'h0);
        chk("sw_req_cycles", 32'(n_req), 32'd3);
        chk("sw_stall_cycles", 32'(n_stall), 32'd4);
        chk("sw_load_valid", 32'(n_lv), 32'd0);
        chk("sw_wstrb", 32'(last_strb), 32'hF);
        chk("sw_wdata", last_wd, 32'hDEADBEEF);

        // SB at offset 3, ready immediately.
        run_op(1'b0, 1'b1, 3'd0, 32'h07, 32'h123456AB, 5'd0, 0, 32'h0);
        chk("sb_addr", last_a, 32'h04);
        chk("sb_wstrb", 32'(last_strb), 32'h8);
        chk("sb_wdata", last_wd, 32'hABABABAB);
        chk("sb_stall_cycles", 32'(n_stall), 32'd2);

        // Load extraction from 0x80FF7F01.
        run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 5'd5, 1, MW);
        chk("lb_data", last_ld, 32'hFFFFFF80);
        chk("lb_rd", 32'(last_rd), 32'd5);
        run_op(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 5'd6, 0, MW);
        chk("lbu_data", last_ld, 32'h00000080);
        chk("lbu_rd", 32'(last_rd), 32'd6);
        run_op(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 5'd7, 0, MW);
        chk("lh_data", last_ld, 32'hFFFF80FF);
        run_op(1'b1, 1'b0, 3'd5, 32'h100, 32'h0, 5'd31, 2, MW);
        chk("lhu_data", last_ld, 32'h00007F01);
        chk("lhu_rd", 32'(last_rd), 32'd31);

        // Rejected accesses.
        run_op(1'b1, 1'b0, 3'd1, 32'h05, 32'h0, 5'd1, 0, MW);
        chk("lh_mis_cause", 32'(last_cause), 32'd1);
        chk("lh_mis_req", 32'(n_req), 32'd0);
        chk("lh_mis_stall", 32'(n_stall), 32'd0);
        run_op(1'b1, 1'b0, 3'd2, 32'h06, 32'h0, 5'd1, 0, MW);
        chk("lw_mis_cause", 32'(last_cause), 32'd1);
        run_op(1'b1, 1'b0, 3'd3, 32'h08, 32'h0, 5'd1, 0, MW);
        chk("f3_011_cause", 32'(last_cause), 32'd2);
        run_op(1'b1, 1'b1, 3'd1, 32'h05, 32'h0, 5'd1, 0, MW);
        chk("rdwr_cause", 32'(last_cause), 32'd2);
        chk("rdwr_req", 32'(n_req), 32'd0);

        // Timeout with ready held low.
        run_op(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 5'd9, 100, MW);
        chk("tmo_req_cycles", 32'(n_req), 32'd4);
        chk("tmo_cause", 32'(last_cause), 32'd3);
        chk("tmo_load_valid", 32'(n_lv), 32'd0);
        chk("tmo_stall_cycles", 32'(n_stall), 32'd5);

        // Randomized operations.
        for (int i = 0; i < 80; i++) begin
            logic        r, w;
            logic [2:0]  f3;
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 9);
            r = (sel != 0) ? (sel < 6) : 1'b1;
            w = (sel != 0) ? (sel >= 6) : 1'b1;
            f3 = f3_tab[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            run_op(r, w, f3, a, $urandom, 5'($urandom), $urandom_range(0, 6), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                addr = $urandom; mem_read = 1'b1;
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of an access.
        chk_en = 1'b0;
        exp_q.delete();
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h20; rd_in = 5'd3;
        op_valid = 1'b1; dm.dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_req", 32'(dm.dmem_req), 32'd1);
        chk("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        op_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        run_op(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, 5'd3, 1, 32'hCAFEF00D);
        chk("post_reset_ld", last_ld, 32'hCAFEF00D);
        chk("post_reset_flt", 32'(n_flt), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
